dbus_arbiter: RTL and testbench

Two-master arbiter for the SoC data bus. It shares the single data read/write port between the CPU (master 0) and a DMA or debug requester (master 1), and routes each granted access to memory or I/O by address. It returns read data to the master that issued the read one cycle later. It sits between the masters and the `memory` / `iosystem` instances, replacing the direct CPU-to-decode wiring.

---
 rtl/dbus_arbiter_if.sv | 27 ++
 rtl/dbus_arbiter.sv | 50 +++++
 tb/tb_dbus_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: master-side requests/returns and downstream data-port signals of the data bus arbiter
interface dbus_arbiter_if;
  logic        m0_req, m1_req;
  logic [15:0] m0_addr, m1_addr;
  logic [1:0]  m0_we, m1_we;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid;
  logic [15:0] dread_addr, dwrite_addr, dwrite_data;
  logic [1:0]  mem_dwrite_en, io_dwrite_en;
  logic [15:0] mem_dread_data, io_dread_data;
  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata,
    input  mem_dread_data, io_dread_data,
    output m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid,
    output dread_addr, dwrite_addr, dwrite_data, mem_dwrite_en, io_dwrite_en
  );
  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wdata, m1_wdata,
    input  m0_gnt, m1_gnt, m0_rdata, m1_rdata, m0_rvalid, m1_rvalid
  );
  modport downstream (
    input  dread_addr, dwrite_addr, dwrite_data, mem_dwrite_en, io_dwrite_en,
    output mem_dread_data, io_dread_data
  );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master data bus arbiter with memory/IO decode and 1-cycle read return
// Optional macro DBUS_ARB_FAIRNESS_EN forces a master-1 grant after STARVE_LIMIT lost contended cycles.
module dbus_arbiter #(
  parameter logic [15:0] MEMADDRBASE  = 16'h2000,
  parameter int          STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  dbus_arbiter_if.slave bus
);
  logic        force_m1, g0, g1, is_mem, rd;
  logic [15:0] addr;
  logic [1:0]  we;
  logic        rd_pending, rd_owner, rd_region;
`ifdef DBUS_ARB_FAIRNESS_EN
  logic [3:0] starve_cnt;
  assign force_m1 = starve_cnt == 4'(STARVE_LIMIT);
  always_ff @(posedge clk) begin
    if (reset || !bus.m1_req || g1) starve_cnt <= '0;
    else if (!force_m1) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign force_m1 = 1'b0;
`endif
  always_comb begin
    g1     = !reset && bus.m1_req && (!bus.m0_req || force_m1);
    g0     = !reset && bus.m0_req && !g1;
    addr   = g1 ? bus.m1_addr : bus.m0_addr;
    we     = g1 ? bus.m1_we : g0 ? bus.m0_we : 2'b00;
    is_mem = addr >= MEMADDRBASE;
    rd     = (g0 || g1) && we == 2'b00;
  end
  assign bus.m0_gnt        = g0;
  assign bus.m1_gnt        = g1;
  assign bus.dread_addr    = addr;
  assign bus.dwrite_addr   = addr;
  assign bus.dwrite_data   = g1 ? bus.m1_wdata : bus.m0_wdata;
  assign bus.mem_dwrite_en = is_mem ? we : 2'b00;
  assign bus.io_dwrite_en  = is_mem ? 2'b00 : we;
  always_ff @(posedge clk) begin
    if (reset) {rd_pending, rd_owner, rd_region} <= '0;
    else {rd_pending, rd_owner, rd_region} <= {rd, g1, is_mem};
  end
  logic [15:0] rsel;
  assign rsel          = rd_region ? bus.mem_dread_data : bus.io_dread_data;
  assign bus.m0_rvalid = rd_pending && !rd_owner && !reset;
  assign bus.m1_rvalid = rd_pending && rd_owner && !reset;
  assign bus.m0_rdata  = bus.m0_rvalid ? rsel : 16'h0000;
  assign bus.m1_rdata  = bus.m1_rvalid ? rsel : 16'h0000;
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed self-checking bench for dbus_arbiter
module tb_dbus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, failures = 0;
`ifdef DBUS_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  dbus_arbiter_if bus();
  dbus_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // registered downstream reads: data is a fixed function of the address
  always @(posedge clk) begin
    bus.mem_dread_data <= bus.dread_addr ^ 16'hA5A5;
    bus.io_dread_data  <= bus.dread_addr ^ 16'h5A5A;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_g0"}, 16'(bus.m0_gnt), 16'h0);
    chk({tag, "_g1"}, 16'(bus.m1_gnt), 16'h0);
    chk({tag, "_rv0"}, 16'(bus.m0_rvalid), 16'h0);
    chk({tag, "_rv1"}, 16'(bus.m1_rvalid), 16'h0);
    chk({tag, "_rd0"}, bus.m0_rdata, 16'h0000);
    chk({tag, "_rd1"}, bus.m1_rdata, 16'h0000);
    chk({tag, "_men"}, 16'(bus.mem_dwrite_en), 16'h0);
    chk({tag, "_ien"}, 16'(bus.io_dwrite_en), 16'h0);
  endtask
  initial begin
    logic e1, p0, p1;
    reset = 1'b1;
    bus.m0_req = 0; bus.m1_req = 0;
    bus.m0_addr = 16'h0; bus.m1_addr = 16'h0;
    bus.m0_we = 2'b00; bus.m1_we = 2'b00;
    bus.m0_wdata = 16'h0; bus.m1_wdata = 16'h0;
    nxt();
    @(negedge clk); chk_quiet("reset");
    nxt(); reset = 1'b0;
    // single reads: m0 memory read then m1 I/O read
    bus.m0_req = 1; bus.m0_addr = 16'h2004;
    @(negedge clk);
    chk("sr_g0", 16'(bus.m0_gnt), 16'h1);
    chk("sr_g1", 16'(bus.m1_gnt), 16'h0);
    nxt();
    bus.m0_req = 0; bus.m1_req = 1; bus.m1_addr = 16'h0010;
    @(negedge clk);
    chk("sr_g1b", 16'(bus.m1_gnt), 16'h1);
    chk("sr_rv0", 16'(bus.m0_rvalid), 16'h1);
    chk("sr_rd0", bus.m0_rdata, 16'h85A1);
    chk("sr_rv1", 16'(bus.m1_rvalid), 16'h0);
    nxt();
    bus.m1_req = 0;
    @(negedge clk);
    chk("sr_rv1b", 16'(bus.m1_rvalid), 16'h1);
    chk("sr_rd1b", bus.m1_rdata, 16'h5A4A);
    chk("sr_rv0b", 16'(bus.m0_rvalid), 16'h0);
    chk("sr_rd0b", bus.m0_rdata, 16'h0000);
    nxt();
    // write decode at the memory boundary
    bus.m1_req = 1; bus.m1_we = 2'b01; bus.m1_addr = 16'h1FFF; bus.m1_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_io_g1", 16'(bus.m1_gnt), 16'h1);
    chk("wr_io_ien", 16'(bus.io_dwrite_en), 16'h1);
    chk("wr_io_men", 16'(bus.mem_dwrite_en), 16'h0);
    chk("wr_io_addr", bus.dwrite_addr, 16'h1FFF);
    chk("wr_io_data", bus.dwrite_data, 16'h1234);
    nxt();
    bus.m1_addr = 16'h2000;
    @(negedge clk);
    chk("wr_mem_men", 16'(bus.mem_dwrite_en), 16'h1);
    chk("wr_mem_ien", 16'(bus.io_dwrite_en), 16'h0);
    chk("wr_mem_rv1", 16'(bus.m1_rvalid), 16'h0);
    nxt();
    bus.m1_req = 0; bus.m1_we = 2'b00;
    @(negedge clk);
    chk("wr_after_rv1", 16'(bus.m1_rvalid), 16'h0);
    nxt();
    // continuous contention for 20 cycles, reads from both masters
    bus.m0_req = 1; bus.m0_addr = 16'h3000;
    bus.m1_req = 1; bus.m1_addr = 16'h0100;
    p0 = 0; p1 = 0;
    for (int i = 0; i < 20; i++) begin
      e1 = FAIR && (i % 5 == 4);
      @(negedge clk);
      chk($sformatf("ct%0d_g1", i), 16'(bus.m1_gnt), 16'(e1));
      chk($sformatf("ct%0d_g0", i), 16'(bus.m0_gnt), 16'(!e1));
      chk($sformatf("ct%0d_rv0", i), 16'(bus.m0_rvalid), 16'(p0));
      chk($sformatf("ct%0d_rd0", i), bus.m0_rdata, p0 ? 16'h95A5 : 16'h0000);
      chk($sformatf("ct%0d_rd1", i), bus.m1_rdata, p1 ? 16'h5B5A : 16'h0000);
      p0 = !e1; p1 = e1;
      nxt();
    end
    bus.m0_req = 0; bus.m1_req = 0;
    @(negedge clk);
    chk("ct_end_rv0", 16'(bus.m0_rvalid), 16'(p0));
    chk("ct_end_rv1", 16'(bus.m1_rvalid), 16'(p1));
    nxt();
    // reset arriving the cycle after a read grant
    bus.m0_req = 1; bus.m0_addr = 16'h2222;
    @(negedge clk);
    chk("rst_g0", 16'(bus.m0_gnt), 16'h1);
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rv0", 16'(bus.m0_rvalid), 16'h0);
    chk("rst_gnt_blocked", 16'(bus.m0_gnt), 16'h0);
    nxt();
    reset = 1'b0; bus.m0_req = 0;
    @(negedge clk); chk_quiet("post_rst");
    nxt();
    // idle bus
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk_quiet($sformatf("idle%0d", i));
      nxt();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
